// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage register.
//   - default widths of the datapath, control vector and destination register
//   - bit positions inside the control vector
//   - state encoding of the stage (ST_SKID only reachable when
//     PIPE_STAGE_REG_SKID_EN is defined)
package pipe_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_DATA = 3;
    localparam int unsigned DEF_CTRL_W   = 7;
    localparam int unsigned DEF_RD_W     = 5;

    // Control vector bit positions
    localparam int unsigned CTRL_BRANCH    = 0;
    localparam int unsigned CTRL_MEMREAD   = 1;
    localparam int unsigned CTRL_MEMTOREG  = 2;
    localparam int unsigned CTRL_MEMWRITE  = 3;
    localparam int unsigned CTRL_REGWRITE  = 4;
    localparam int unsigned CTRL_JUMP      = 5;
    localparam int unsigned CTRL_ZERO      = 6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
// Ports:
//   clk    - clock
//   clr_n  - synchronous active-low clear
//   inc    - add one this cycle (ignored once saturated)
//   count  - current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register (EX/MEM latch replacement).
// Optional feature macro: PIPE_STAGE_REG_SKID_EN adds a one-entry skid buffer
// and makes in_ready a registered signal (no out_ready -> in_ready path).
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - upstream handshake
//   in_data/ctrl/rd     - incoming payload (word 0 in the LSBs of in_data)
//   flush               - discard everything held, refuse input this cycle
//   out_valid/out_ready - downstream handshake
//   out_data/ctrl/rd    - held payload; out_ctrl is zero whenever out_valid=0
//   stall_cnt           - saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_DATA = DEF_NUM_DATA,
    parameter int unsigned CTRL_W   = DEF_CTRL_W,
    parameter int unsigned RD_W     = DEF_RD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [RD_W-1:0]            in_rd,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [RD_W-1:0]            out_rd,
    output logic [15:0]                stall_cnt
);

    state_t                     state;
    state_t                     next_state;
    logic [NUM_DATA*DATA_W-1:0] data_q;
    logic [CTRL_W-1:0]          ctrl_q;
    logic [RD_W-1:0]            rd_q;
    logic                       in_xfer;
    logic                       out_xfer;
    logic                       stall_inc;

    // flush wins over a simultaneous in_valid
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) next_state = ST_FULL;
            end
            ST_FULL: begin
                if (out_xfer && !in_xfer) next_state = ST_EMPTY;
`ifdef PIPE_STAGE_REG_SKID_EN
                else if (in_xfer && !out_xfer) next_state = ST_SKID;
`endif
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            ST_SKID: begin
                if (out_xfer) next_state = ST_FULL;
            end
`endif
            default: next_state = ST_EMPTY;
        endcase
        if (flush) next_state = ST_EMPTY;
    end

    // ---------------- outputs ----------------
`ifdef PIPE_STAGE_REG_SKID_EN
    logic                       ready_q;
    logic [NUM_DATA*DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0]          skid_ctrl;
    logic [RD_W-1:0]            skid_rd;

    // Registered readiness; gating with rst_n keeps in_ready low during reset
    // while still allowing an accept on the first cycle after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (next_state != ST_SKID);
        end
    end
`endif

    always_comb begin
        out_valid = (state != ST_EMPTY);
`ifdef PIPE_STAGE_REG_SKID_EN
        in_ready  = ready_q && rst_n;
`else
        in_ready  = rst_n && (out_ready || (state == ST_EMPTY));
`endif
    end

    assign out_data = data_q;
    assign out_rd   = rd_q;
    assign out_ctrl = out_valid ? ctrl_q : '0;

    // ---------------- payload ----------------
`ifdef PIPE_STAGE_REG_SKID_EN
    // Input lands in the output slot when that slot is free (or being freed);
    // otherwise it parks in the skid entry, which refills the slot next drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= '0;
            rd_q   <= '0;
        end else if (state == ST_SKID) begin
            if (out_xfer) begin
                data_q <= skid_data;
                ctrl_q <= skid_ctrl;
                rd_q   <= skid_rd;
            end
        end else if (in_xfer && ((state == ST_EMPTY) || out_xfer)) begin
            data_q <= in_data;
            ctrl_q <= in_ctrl;
            rd_q   <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
        end else if (in_xfer && (state == ST_FULL) && !out_xfer) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            skid_rd   <= in_rd;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= '0;
            rd_q   <= '0;
        end else if (in_xfer) begin
            data_q <= in_data;
            ctrl_q <= in_ctrl;
            rd_q   <= in_rd;
        end
    end
`endif

    // ---------------- stall counter ----------------
    sat_counter #(
        .WIDTH(16)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (default widths).
// Works with and without PIPE_STAGE_REG_SKID_EN; the model follows the macro.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic [6:0]  in_ctrl;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [6:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic [15:0] stall_cnt;

    pipe_stage_reg #(
        .DATA_W   (32),
        .NUM_DATA (3),
        .CTRL_W   (7),
        .RD_W     (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] d;
        logic [6:0]  c;
        logic [4:0]  r;
    } ent_t;

    ent_t        q[$];
    logic [15:0] exp_stall;
    logic        last_acc;
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: drive, compare against the model, then
    // advance the model over the following posedge.
    task automatic step(input logic rv, input logic v, input logic [95:0] d,
                        input logic [6:0] c, input logic [4:0] r,
                        input logic f, input logic ordy, input bit chk);
        logic exp_rdy;
        ent_t e;
        rst_n = rv; in_valid = v; in_data = d; in_ctrl = c; in_rd = r;
        flush = f; out_ready = ordy;
        #1;
`ifdef PIPE_STAGE_REG_SKID_EN
        exp_rdy = rv && (q.size() < 2);
`else
        exp_rdy = rv && (ordy || (q.size() == 0));
`endif
        if (chk) begin
            check("in_ready", 96'(in_ready), 96'(exp_rdy));
            check("out_valid", 96'(out_valid), 96'(q.size() != 0));
            check("stall_cnt", 96'(stall_cnt), 96'(exp_stall));
            if (q.size() != 0) begin
                check("out_data", out_data, q[0].d);
                check("out_ctrl", 96'(out_ctrl), 96'(q[0].c));
                check("out_rd", 96'(out_rd), 96'(q[0].r));
            end else begin
                check("bubble_ctrl", 96'(out_ctrl), 96'(0));
            end
        end
        last_acc = 1'b0;
        @(posedge clk);
        if (!rv) begin
            q.delete();
            exp_stall = '0;
        end else begin
            if ((q.size() != 0) && !ordy && (exp_stall != 16'hFFFF)) exp_stall++;
            if (f) begin
                q.delete();
            end else begin
                if ((q.size() != 0) && ordy) void'(q.pop_front());
                if (v && exp_rdy) begin
                    e.d = d; e.c = c; e.r = r;
                    q.push_back(e);
                    last_acc = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    localparam logic [95:0] A_D = {32'hA2, 32'hA1, 32'hA0};
    localparam logic [95:0] B_D = {32'hB2, 32'hB1, 32'hB0};
    localparam logic [95:0] F_D = {32'hF2, 32'hF1, 32'hF0};

    initial begin
        logic pend;
        n_tests = 0; n_fail = 0; exp_stall = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_rd = '0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // Reset with in_valid held high
        step(0, 1, A_D, 7'h10, 5'd1, 0, 1, 0);
        step(0, 1, A_D, 7'h10, 5'd1, 0, 1, 1);
        check("rst_out_data", out_data, 96'(0));
        check("rst_out_rd", 96'(out_rd), 96'(0));

        // Streaming: one word set per cycle, out_ready held high
        for (int k = 1; k <= 3; k++)
            step(1, 1, {32'(k*16+2), 32'(k*16+1), 32'(k*16)}, 7'(k), 5'(k), 0, 1, 1);
        step(1, 0, '0, '0, '0, 0, 1, 1);
        step(1, 0, '0, '0, '0, 0, 1, 1);
        check("stream_stall", 96'(stall_cnt), 96'(0));

        // Backpressure: A held for 5 stalled cycles while B is offered
        step(1, 1, A_D, 7'h10, 5'd3, 0, 0, 1);
        pend = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1, pend, B_D, 7'h0A, 5'd4, 0, 0, 1);
            if (last_acc) pend = 1'b0;
        end
        check("bp_stall5", 96'(stall_cnt), 96'(5));
        check("bp_hold_a", out_data, A_D);
`ifdef PIPE_STAGE_REG_SKID_EN
        check("bp_b_in_skid", 96'(pend), 96'(0));
`else
        check("bp_not_ready", 96'(in_ready), 96'(0));
`endif
        for (int k = 0; k < 10 && pend; k++) begin
            step(1, pend, B_D, 7'h0A, 5'd4, 0, 1, 1);
            if (last_acc) pend = 1'b0;
        end
        check("bp_b_accept", 96'(pend), 96'(0));
        for (int k = 0; k < 3; k++) step(1, 0, '0, '0, '0, 0, 1, 1);

        // Flush while FULL with RegWrite set, in_valid high
        step(1, 1, F_D, 7'h10, 5'd7, 0, 0, 1);
        step(1, 1, B_D, 7'h10, 5'd8, 1, 0, 1);
        check("flush_valid", 96'(out_valid), 96'(0));
        check("flush_ctrl", 96'(out_ctrl), 96'(0));
        check("flush_nocap", out_data, F_D);
        step(1, 0, '0, '0, '0, 0, 1, 1);

        // Mid-operation reset with two entries offered under backpressure
        step(1, 1, A_D, 7'h11, 5'd9, 0, 0, 1);
        step(1, 1, B_D, 7'h12, 5'd10, 0, 0, 1);
        step(0, 1, F_D, 7'h13, 5'd11, 0, 0, 1);
        step(1, 0, '0, '0, '0, 0, 1, 1);
        check("midrst_valid", 96'(out_valid), 96'(0));
        step(1, 0, '0, '0, '0, 0, 1, 1);

        // Random traffic with occasional flush
        for (int k = 0; k < 300; k++)
            step(1, $urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
                 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1);

        // Saturation: 70000 stalled cycles
        step(1, 1, A_D, 7'h10, 5'd2, 0, 0, 1);
        for (int k = 0; k < 70000; k++) step(1, 0, '0, '0, '0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, '0, '0, '0, 0, 0, 1);
        check("sat_ffff", 96'(stall_cnt), 96'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of one datapath word.
REQ-002 Parameter NUM_DATA, default 3: number of datapath words carried, e.g. PC_next, ALU result, read data 2.
REQ-003 Parameter CTRL_W, default 7: control-bit vector width (Branch, MemRead, MemToReg, MemWrite, RegWrite, Jump, Zero).
REQ-004 Parameter RD_W, default 5: destination-register index width.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 rst_n  in  1  reset; synchronous and active-low.
REQ-007 in_valid  in  1  upstream stage holds a valid instruction.
REQ-008 in_ready  out  1  stage accepts in_* this cycle.
REQ-009 in_data  in  NUM_DATA*DATA_W  packed datapath words; word 0 in the LSBs.
REQ-010 in_ctrl  in  CTRL_W  control bits.
REQ-011 in_rd  in  RD_W  destination register.
REQ-012 flush  in  1  kill all held entries (branch/jump redirect).
REQ-013 out_valid  out  1  stage holds a valid instruction.
REQ-014 out_ready  in  1  downstream consumes this cycle.
REQ-015 out_data, out_ctrl, out_rd  out  widths as inputs  held payload.
REQ-016 stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to out_valid=1 when empty.
REQ-019 States: EMPTY (out_valid=0) and FULL (out_valid=1); with SKID_EN also SKID (FULL plus one buffered entry).
REQ-020 EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL on simultaneous transfers, with payload replaced by the new input.
REQ-021 Payload registers SHALL load only on an input transfer, holding unchanged otherwise (stall).
REQ-022 out_ctrl SHALL read all-zero whenever out_valid=0, so an invalid slot is always a bubble (no RegWrite/MemWrite).
REQ-023 flush=1 SHALL force next state EMPTY, discard skid contents, and block acceptance that cycle (flush beats simultaneous in_valid).
REQ-024 flush SHALL NOT alter stall_cnt.
REQ-025 stall_cnt SHALL increment by 1 per stalled cycle, saturate at 16'hFFFF, and never wrap.
REQ-026 in_ready SHALL never depend on in_valid.

Reset
REQ-027 rst_n=0 at posedge clk SHALL set state EMPTY, out_valid=0, out_ctrl=0, out_rd=0, out_data=0, stall_cnt=0, and clear the skid entry.
REQ-028 Reset SHALL override flush and any in-flight transfer; the first accept after reset SHALL be possible on the first cycle with rst_n=1.
REQ-029 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-030 Macro PIPE_STAGE_REG_SKID_EN defined: in_ready SHALL be a register output equal to (state!=SKID); a transfer arriving in FULL while out_ready=0 SHALL be stored in the skid entry (FULL->SKID); on the next output transfer the skid entry moves to the output slot (SKID->FULL); full throughput SHALL be sustained with no combinational out_ready->in_ready path.
REQ-031 Macro undefined: in_ready = out_ready || !out_valid (combinational), SKID state and skid storage absent, all other behaviour identical.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the state encoding constants (ST_EMPTY, ST_FULL, ST_SKID), control-bit index constants, and the default widths.
REQ-033 The saturating counter SHALL be a sub-module sat_counter (WIDTH parameter, inc input, synchronous active-low clear).
REQ-034 Defaults (3x32 data, 7 ctrl, 5 rd) SHALL be a drop-in replacement for the existing fixed EX/MEM latch with stall-free traffic.

Verification
REQ-035 Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=0.
REQ-036 Streaming: in_valid=1, out_ready=1, in_data words 0x10,0x20,0x30 per cycle -> same payload on out_data 1 cycle later each cycle, stall_cnt=0.
REQ-037 Backpressure: accept A (ctrl=7'h10), hold out_ready=0 for 5 cycles -> out_data=A stable, stall_cnt=5; without SKID_EN, in_ready=0; with SKID_EN, B accepted into skid and emitted directly after A.
REQ-038 Flush: FULL with ctrl RegWrite=1, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, input not captured.
REQ-039 Saturation: force 70000 stalled cycles -> stall_cnt=16'hFFFF and holds.
REQ-040 Mid-operation reset in SKID state -> next cycle EMPTY, skid entry lost, no stale output after reset release.
